qpp_interleaver: RTL
====================

Name: qpp_interleaver

Overview:
- Parametrised turbo-encoder interleaver. Generates the QPP permutation at run time, so it covers any block size K up to KMAX without per-size permutation ROMs.
- Sits between the CRC attach stage and the second constituent encoder.
- Two ping-pong RAM banks: one bank fills in natural order while the other drains in permuted order. This sustains one symbol per clock across back-to-back blocks.

Parameters:
- DW, 1, data symbol width in bits
- KMAX, 6144, largest supported block size
- AW, 13, address/index width; must satisfy 2**AW >= KMAX

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_start  in  1  first beat of a block; latches k_in, f1_in, f2_in
- in_valid  in  1  data_in beat valid
- in_end  in  1  last beat of a block
- data_in  in  DW  input symbol, natural order
- k_in  in  AW  block size K, legal range 40..KMAX
- f1_in  in  AW  QPP coefficient f1 < K
- f2_in  in  AW  QPP coefficient f2 < K
- in_ready  out  1  a write bank is EMPTY or FILLING
- out_valid  out  1  data_out valid
- out_sop  out  1  first output symbol of a block
- out_eop  out  1  last output symbol of a block
- data_out  out  DW  permuted symbol c(pi(i))
- done  out  1  one-cycle pulse on the cycle after out_eop
- err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset (async, reset=0):
  - Outputs: in_ready=0, out_valid=0, out_sop=0, out_eop=0, data_out=0, done=0, err=0.
  - Both banks EMPTY; write and read bank pointers set to bank 0; counters and registered K/f1/f2 cleared.
  - in_ready rises on the first clk after reset deasserts. RAM contents are not cleared.
- Bank state, per bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY. K, f1 and f2 are stored per bank.
- Write side:
  - A beat is accepted when in_valid & in_ready.
  - in_start with a valid beat moves the current write bank EMPTY->FILLING, latches K/f1/f2, and writes at address 0.
  - The write index increments per accepted beat.
  - The beat at index K-1 must carry in_end. The bank then goes FULL and the write pointer toggles.
  - in_ready=0 while the next write bank is not EMPTY.
- Framing errors (each pulses err for one cycle):
  - in_end at index < K-1: block discarded, bank returns to EMPTY.
  - Index K-1 reached without in_end: bank still goes FULL; beats before the next in_start are dropped.
  - in_start while FILLING: current block discarded; the new block restarts at index 0 in the same bank.
  - in_valid without in_start while EMPTY: beat dropped.
- Read side:
  - When the reader is idle and the read bank is FULL, it enters DRAINING on the next clk.
  - Read addresses are pi(i) for i = 0..K-1, one per clock, with no gaps and no backpressure.
  - Latency: out_valid with pi(0) data is asserted 2 cycles after DRAINING entry (address register + synchronous RAM read).
  - out_sop accompanies i=0 and out_eop accompanies i=K-1. done pulses the following cycle; the bank goes EMPTY and the read pointer toggles.
  - If the other bank is already FULL, its DRAINING starts on the cycle after out_eop, so output is continuous with one idle cycle between blocks.
- Address generation (no multipliers):
  - pi(i) = (f1*i + f2*i*i) mod K.
  - Init: pi=0, g=(f1+f2) mod K.
  - Each step: pi <= (pi+g) mod K; g <= (g+2*f2) mod K.
  - Each modular add uses one subtract-if->=K stage on AW+1-bit sums; all intermediates stay < K.
- Simultaneous events: a write to one bank and a read from the other in the same cycle are legal. The same bank is never both written and read.
- Out-of-range K (K<40 or K>KMAX): err pulses at in_start and the block is ignored.

Optional Feature:
- Macro: QPP_INTERLEAVER_DEINT_EN.
- Defined:
  - Adds input port deint_mode (1 bit), latched per bank at in_start.
  - When deint_mode=1, writes go to address pi(i) and reads are linear 0..K-1, giving the inverse permutation. The address generator advances on the write side.
  - Latency and handshakes are unchanged.
- Undefined: the port is absent and the block always interleaves.

Test Plan:
- Reset mid-drain: assert reset during a drain, then deassert -> all outputs 0 on the reset cycle, in_ready=1 on the next clk, a fresh block is processed correctly.
- Single block, DW=8, K=40, f1=3, f2=10, data_in=i:
  - Output sequence starts 0,13,6,19; 40 symbols total.
  - out_sop on the first, out_eop on the 40th; done one cycle later.
  - First out_valid exactly 2 clks after DRAINING entry.
- Back-to-back blocks, K=40 then K=6144 (f1=263, f2=480):
  - in_ready stays 1 across both blocks.
  - Outputs match a golden-model QPP for both blocks; one idle cycle between them.
- Early in_end at beat 20 with K=40 -> err pulses once, no output, next block is correct.
- Third block offered while both banks are FULL/DRAINING -> in_ready=0 until the first block's done, no data loss.
- QPP_INTERLEAVER_DEINT_EN defined: interleave then deinterleave a K=40 block -> the original sequence 0..39 is recovered.

Source files
------------

// File: rtl/qpp_interleaver.sv
// Ping-pong QPP turbo interleaver: one bank fills in natural order while the other drains at pi(i).
// Define QPP_INTERLEAVER_DEINT_EN to add the deint_mode input (writes at pi(i), linear reads).
module qpp_interleaver #(
    parameter int DW   = 1,
    parameter int KMAX = 6144,
    parameter int AW   = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_start,
    input  logic          in_valid,
    input  logic          in_end,
    input  logic [DW-1:0] data_in,
    input  logic [AW-1:0] k_in,
    input  logic [AW-1:0] f1_in,
    input  logic [AW-1:0] f2_in,
`ifdef QPP_INTERLEAVER_DEINT_EN
    input  logic          deint_mode,
`endif
    output logic          in_ready,
    output logic          out_valid,
    output logic          out_sop,
    output logic          out_eop,
    output logic [DW-1:0] data_out,
    output logic          done,
    output logic          err
);
    localparam logic [1:0]    B_EMPTY    = 2'd0;
    localparam logic [1:0]    B_FILLING  = 2'd1;
    localparam logic [1:0]    B_FULL     = 2'd2;
    localparam logic [1:0]    B_DRAINING = 2'd3;
    localparam logic [0:0]    RD_IDLE    = 1'b0;
    localparam logic [0:0]    RD_RUN     = 1'b1;
    localparam logic [AW-1:0] ONE        = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   KMIN_W     = (AW+1)'(40);
    localparam logic [AW:0]   KMAX_W     = (AW+1)'(KMAX);

    // (a + b) mod k for a, b < k: one compare/subtract on an AW+1 bit sum
    function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                              input logic [AW-1:0] k);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, k}) ? (s[AW-1:0] - k) : s[AW-1:0];
    endfunction

    logic [1:0][1:0]    bank_st_q, bank_st_d;
    logic [1:0][AW-1:0] k_q, k_d, f1_q, f1_d, f2_q, f2_d;
    logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [AW-1:0]      pi_q, pi_d, g_q, g_d, rd_addr_q, rd_addr_d;
    logic [0:0]         rd_st_q, rd_st_d;
    logic               v1_q, v1_d, sop1_q, sop1_d, eop1_q, eop1_d, bank1_q, bank1_d, bank2_q;
    logic               in_ready_q, in_ready_d, err_q, err_d;
    logic               out_valid_q, out_sop_q, out_eop_q, done_q;
    logic [DW-1:0]      data_out_q;
    logic               we_s, k_bad_s, rd_deint_s;
    logic [AW-1:0]      waddr_s;
    logic [DW-1:0]      mem [0:(2**(AW+1))-1];
`ifdef QPP_INTERLEAVER_DEINT_EN
    logic [1:0]         deint_q, deint_d;
    logic [AW-1:0]      wpi_q, wpi_d, wg_q, wg_d;
    assign rd_deint_s = deint_q[rd_ptr_q];
`else
    assign rd_deint_s = 1'b0;
`endif

    assign k_bad_s = ({1'b0, k_in} < KMIN_W) || ({1'b0, k_in} > KMAX_W);

    // Bank state machine, write-side framing and read-side address generation
    always_comb begin
        bank_st_d = bank_st_q;
        k_d       = k_q;
        f1_d      = f1_q;
        f2_d      = f2_q;
        wr_ptr_d  = wr_ptr_q;
        wr_idx_d  = wr_idx_q;
        err_d     = 1'b0;
        we_s      = 1'b0;
        waddr_s   = wr_idx_q;
        rd_st_d   = rd_st_q;
        rd_ptr_d  = rd_ptr_q;
        rd_idx_d  = rd_idx_q;
        pi_d      = pi_q;
        g_d       = g_q;
        rd_addr_d = rd_addr_q;
        bank1_d   = bank1_q;
        v1_d      = 1'b0;
        sop1_d    = 1'b0;
        eop1_d    = 1'b0;
`ifdef QPP_INTERLEAVER_DEINT_EN
        deint_d = deint_q;
        wpi_d   = wpi_q;
        wg_d    = wg_q;
        if (deint_q[wr_ptr_q]) begin
            waddr_s = wpi_q;
        end else begin
            waddr_s = wr_idx_q;
        end
`endif
        if (in_valid && in_ready_q) begin
            if (in_start) begin
                if (k_bad_s || in_end) begin
                    err_d               = 1'b1;
                    bank_st_d[wr_ptr_q] = B_EMPTY;
                end else begin
                    err_d               = (bank_st_q[wr_ptr_q] == B_FILLING);
                    bank_st_d[wr_ptr_q] = B_FILLING;
                    k_d[wr_ptr_q]       = k_in;
                    f1_d[wr_ptr_q]      = f1_in;
                    f2_d[wr_ptr_q]      = f2_in;
                    we_s                = 1'b1;
                    waddr_s             = '0;
                    wr_idx_d            = ONE;
`ifdef QPP_INTERLEAVER_DEINT_EN
                    deint_d[wr_ptr_q] = deint_mode;
                    wpi_d = mod_add(f1_in, f2_in, k_in);
                    wg_d  = mod_add(wpi_d, mod_add(f2_in, f2_in, k_in), k_in);
`endif
                end
            end else if (bank_st_q[wr_ptr_q] == B_FILLING) begin
                we_s = 1'b1;
                if (wr_idx_q == k_q[wr_ptr_q] - ONE) begin
                    bank_st_d[wr_ptr_q] = B_FULL;
                    wr_ptr_d            = ~wr_ptr_q;
                    err_d               = ~in_end;
                end else if (in_end) begin
                    bank_st_d[wr_ptr_q] = B_EMPTY;
                    err_d               = 1'b1;
                end else begin
                    wr_idx_d = wr_idx_q + ONE;
`ifdef QPP_INTERLEAVER_DEINT_EN
                    wpi_d = mod_add(wpi_q, wg_q, k_q[wr_ptr_q]);
                    wg_d  = mod_add(wg_q, mod_add(f2_q[wr_ptr_q], f2_q[wr_ptr_q], k_q[wr_ptr_q]),
                                    k_q[wr_ptr_q]);
`endif
                end
            end else begin
                err_d = 1'b1;
            end
        end else begin
            err_d = 1'b0;
        end

        case (rd_st_q)
            RD_IDLE: begin
                if (bank_st_q[rd_ptr_q] == B_FULL) begin
                    bank_st_d[rd_ptr_q] = B_DRAINING;
                    rd_st_d             = RD_RUN;
                    rd_idx_d            = '0;
                    pi_d                = '0;
                    g_d = mod_add(f1_q[rd_ptr_q], f2_q[rd_ptr_q], k_q[rd_ptr_q]);
                end else begin
                    rd_st_d = RD_IDLE;
                end
            end
            RD_RUN: begin
                v1_d      = 1'b1;
                bank1_d   = rd_ptr_q;
                rd_addr_d = rd_deint_s ? rd_idx_q : pi_q;
                sop1_d    = (rd_idx_q == '0);
                eop1_d    = (rd_idx_q == k_q[rd_ptr_q] - ONE);
                if (eop1_d) begin
                    rd_st_d  = RD_IDLE;
                    rd_ptr_d = ~rd_ptr_q;
                end else begin
                    rd_idx_d = rd_idx_q + ONE;
                    pi_d     = mod_add(pi_q, g_q, k_q[rd_ptr_q]);
                    g_d      = mod_add(g_q, mod_add(f2_q[rd_ptr_q], f2_q[rd_ptr_q], k_q[rd_ptr_q]),
                                       k_q[rd_ptr_q]);
                end
            end
            default: rd_st_d = RD_IDLE;
        endcase

        // The bank is released once its last symbol has left the output register
        if (out_eop_q) begin
            bank_st_d[bank2_q] = B_EMPTY;
        end else begin
            bank_st_d[bank2_q] = bank_st_d[bank2_q];
        end
        in_ready_d = (bank_st_d[wr_ptr_d] == B_EMPTY) || (bank_st_d[wr_ptr_d] == B_FILLING);
    end

    // Control, generator and output pipeline registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_st_q   <= '0;
            k_q         <= '0;
            f1_q        <= '0;
            f2_q        <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            pi_q        <= '0;
            g_q         <= '0;
            rd_addr_q   <= '0;
            rd_st_q     <= RD_IDLE;
            v1_q        <= 1'b0;
            sop1_q      <= 1'b0;
            eop1_q      <= 1'b0;
            bank1_q     <= 1'b0;
            bank2_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            data_out_q  <= '0;
            done_q      <= 1'b0;
`ifdef QPP_INTERLEAVER_DEINT_EN
            deint_q <= '0;
            wpi_q   <= '0;
            wg_q    <= '0;
`endif
        end else begin
            bank_st_q   <= bank_st_d;
            k_q         <= k_d;
            f1_q        <= f1_d;
            f2_q        <= f2_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            pi_q        <= pi_d;
            g_q         <= g_d;
            rd_addr_q   <= rd_addr_d;
            rd_st_q     <= rd_st_d;
            v1_q        <= v1_d;
            sop1_q      <= sop1_d;
            eop1_q      <= eop1_d;
            bank1_q     <= bank1_d;
            bank2_q     <= bank1_q;
            in_ready_q  <= in_ready_d;
            err_q       <= err_d;
            out_valid_q <= v1_q;
            out_sop_q   <= v1_q & sop1_q;
            out_eop_q   <= v1_q & eop1_q;
            data_out_q  <= v1_q ? mem[{bank1_q, rd_addr_q}] : '0;
            done_q      <= out_eop_q;
`ifdef QPP_INTERLEAVER_DEINT_EN
            deint_q <= deint_d;
            wpi_q   <= wpi_d;
            wg_q    <= wg_d;
`endif
        end
    end

    // Symbol RAM write port; both banks share one array split by the bank bit
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[{wr_ptr_q, waddr_s}] <= data_in;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign data_out  = data_out_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule
